npu_result_drain: RTL and testbench
===================================

// Module: npu_result_drain
// PURPOSE
//  Downstream stage of the NPU core. It captures each result tile (results_flat qualified by
//  result_valid) into a 2-slot ping-pong frame buffer. It then serialises the tile as a
//  valid/ready stream of OUT_WIDTH-bit beats toward host/DMA writeback.
//  This decouples array drain timing from a slow consumer and flags tiles lost to backpressure.
// PARAMETERS
//  ARRAY_SIZE  `ARRAY_SIZE        PE rows/cols; one tile = ARRAY_SIZE*ARRAY_SIZE accumulators
//  ACC_WIDTH   `ACC_WIDTH         bits per accumulator; must be a multiple of OUT_WIDTH
//  OUT_WIDTH   `HOST_DATA_WIDTH   bits per output beat
//  (derived) BPE=ACC_WIDTH/OUT_WIDTH beats/element; BEATS=ARRAY_SIZE*ARRAY_SIZE*BPE beats/tile
// PORTS
//  clk             in   1                        clock, rising edge
//  rst_n           in   1                        asynchronous active-low reset
//  results_flat    in   ARRAY_SIZE^2*ACC_WIDTH   tile from core; element e = [e*ACC_WIDTH +: ACC_WIDTH]
//  result_valid    in   1                        1-cycle strobe: results_flat holds a complete tile
//  clear           in   1                        synchronous flush of buffer, stream and flags
//  out_valid       out  1                        out_data holds a valid beat
//  out_ready       in   1                        consumer accepts the beat when out_valid&out_ready
//  out_data        out  OUT_WIDTH                current beat
//  out_last        out  1                        high on the final beat of a tile
//  busy            out  1                        at least one slot is occupied
//  overflow        out  1                        sticky: at least one tile was dropped
//  frames_dropped  out  8                        saturating count of dropped tiles
// BEHAVIOUR
//  Reset: all outputs 0; both slots empty; read/write pointers 0; beat counter 0; FSM IDLE.
//  Storage: two tile registers (slot0, slot1) plus a wr_ptr, a rd_ptr and a 2-bit occupancy count.
//  Capture: on a cycle with result_valid=1 and a free slot, results_flat is written to slot[wr_ptr];
//    wr_ptr toggles and count increments.
//    - Free slot test: count<2, OR the final beat of a tile is accepted that same cycle
//      (slot freed and refilled in one cycle).
//  Drop: result_valid=1 with no free slot -> tile discarded; overflow<=1;
//    frames_dropped increments (holds at 255); stored tiles are untouched.
//  FSM IDLE: out_valid=0. Moves to STREAM on the edge after count becomes nonzero, so the first
//    beat appears on the cycle after capture (capture edge N -> out_valid=1 in cycle N+1).
//  FSM STREAM: out_valid=1.
//    - out_data = slot[rd_ptr] element (beat/BPE), sub-word (beat%BPE).
//    - Sub-words go low half first; elements go in index order 0..ARRAY_SIZE^2-1.
//    - On each accepted beat the counter increments.
//    - out_last=1 when beat==BEATS-1. Accepting that beat frees the slot, toggles rd_ptr and
//      resets beat to 0.
//    - After the last beat the FSM stays in STREAM if the other slot is (or becomes) occupied,
//      giving back-to-back tiles with no bubble. Otherwise it returns to IDLE.
//  Stream rules: while out_valid&!out_ready, out_data and out_last are held stable.
//    out_valid never drops without a handshake, except on clear or reset.
//  Simultaneous capture and pop in the same cycle: count is unchanged and both pointers toggle.
//  clear: takes priority over result_valid and a handshake in the same cycle.
//    - Next cycle: slots empty, pointers and beat 0, FSM IDLE, out_valid=0, overflow=0,
//      frames_dropped=0.
//    - A tile presented in the clear cycle is neither captured nor counted as dropped.
//  Reset mid-stream: immediate return to the reset state; a partially sent tile is abandoned.
//  No arithmetic on data: bits pass through unmodified.
// TESTING (bench: ARRAY_SIZE=4, ACC_WIDTH=32, OUT_WIDTH=16 -> BPE=2, BEATS=32)
//  1. Load element e = 32'hA000_0000+e, pulse result_valid, out_ready=1.
//     -> out_valid rises next cycle. 32 beats: 16'h0000, 16'hA000, 16'h0001, 16'hA000, ...
//     out_last only on beat 31. busy falls after the last beat.
//  2. Tile A accepted, out_ready=0 for 10 cycles, then 1.
//     -> out_data holds 16'h0000 throughout the stall; the stream then completes with no loss
//     or duplication.
//  3. out_ready=0; tiles A, B, C pulsed on cycles 0, 2, 4.
//     -> A and B buffered; C dropped; overflow=1; frames_dropped=1.
//     Release out_ready -> 64 beats, A then B, back-to-back with no bubble.
//  4. Two slots full; result_valid for tile D in the same cycle as A's last beat is accepted.
//     -> D captured, no drop. Stream continues with B then D.
//  5. clear asserted mid-tile at beat 7 while result_valid=1.
//     -> next cycle out_valid=0, busy=0, overflow=0, frames_dropped=0; the tile is not captured.
//  6. 300 drops with out_ready=0 -> frames_dropped saturates at 255.
//     Reset asserted mid-stream -> all outputs 0 at once.

Source files
------------

// File: rtl/npu_result_drain.sv
// Result drain for the NPU core: captures whole result tiles into a two-slot
// ping-pong buffer and streams them out as OUT_WIDTH-bit valid/ready beats.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   ST_IDLE   | no tile buffered, out_valid low
//   ST_STREAM | presenting beats of slot[rd_ptr], out_valid high
module npu_result_drain #(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*ACC_WIDTH-1:0] results_flat,
  input  logic                                     result_valid,
  input  logic                                     clear,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [OUT_WIDTH-1:0]                     out_data,
  output logic                                     out_last,
  output logic                                     busy,
  output logic                                     overflow,
  output logic [7:0]                               frames_dropped
);

  localparam int ELEMS  = ARRAY_SIZE * ARRAY_SIZE;
  localparam int BPE    = ACC_WIDTH / OUT_WIDTH;
  localparam int BEATS  = ELEMS * BPE;
  localparam int TILE_W = ELEMS * ACC_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [TILE_W-1:0]    slot0;
  logic [TILE_W-1:0]    slot1;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic [BEAT_W-1:0]    beat;
  logic [0:0]           state;
  logic [0:0]           state_next;
  logic [TILE_W-1:0]    rd_tile;
  logic [OUT_WIDTH-1:0] beat_words [BEATS];

  logic streaming;
  logic pop;
  logic last_beat;
  logic pop_last;
  logic slot_free;
  logic capture;
  logic drop;

  assign streaming = (state == ST_STREAM);
  assign pop       = streaming & out_ready;
  assign last_beat = streaming & (beat == LAST_BEAT);
  assign pop_last  = pop & last_beat;

  // A slot being vacated by the final handshake can be refilled on the same edge.
  assign slot_free = (count < 2'd2) | pop_last;
  assign capture   = result_valid & slot_free;
  assign drop      = result_valid & ~slot_free;

  always_comb begin
    count_next = count;
    case ({capture, pop_last})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (count_next != 2'd0) state_next = ST_STREAM;
      ST_STREAM: if (count_next == 2'd0) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Elements are packed low-index first and sub-words low half first, so the
  // tile word is already in beat order.
  assign rd_tile = rd_ptr ? slot1 : slot0;

  always_comb begin
    for (int b = 0; b < BEATS; b++) begin
      beat_words[b] = rd_tile[b*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign out_valid = streaming;
  assign out_data  = streaming ? beat_words[beat] : '0;
  assign out_last  = last_beat;
  assign busy      = (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0          <= '0;
      slot1          <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= 2'd0;
      beat           <= '0;
      state          <= ST_IDLE;
      overflow       <= 1'b0;
      frames_dropped <= 8'd0;
    end else if (clear) begin
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      count          <= 2'd0;
      beat           <= '0;
      state          <= ST_IDLE;
      overflow       <= 1'b0;
      frames_dropped <= 8'd0;
    end else begin
      if (capture) begin
        if (wr_ptr) slot1 <= results_flat;
        else        slot0 <= results_flat;
        wr_ptr <= ~wr_ptr;
      end
      if (pop_last) rd_ptr <= ~rd_ptr;
      if (pop) beat <= pop_last ? '0 : beat + 1'b1;
      count <= count_next;
      state <= state_next;
      if (drop) begin
        overflow <= 1'b1;
        if (frames_dropped != 8'hFF) frames_dropped <= frames_dropped + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_npu_result_drain.sv
// Directed bench for npu_result_drain: expected beats are queued when a tile is
// presented and checked against every accepted beat.
module tb_npu_result_drain;

  localparam int ARRAY_SIZE = 4;
  localparam int ACC_WIDTH  = 32;
  localparam int OUT_WIDTH  = 16;
  localparam int ELEMS      = ARRAY_SIZE * ARRAY_SIZE;
  localparam int TILE_W     = ELEMS * ACC_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [TILE_W-1:0]    results_flat;
  logic                 result_valid;
  logic                 clear;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;
  logic                 out_last;
  logic                 busy;
  logic                 overflow;
  logic [7:0]           frames_dropped;

  int total = 0;
  int bad   = 0;
  logic [16:0] sb [$];

  npu_result_drain #(
    .ARRAY_SIZE(ARRAY_SIZE),
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .results_flat  (results_flat),
    .result_valid  (result_valid),
    .clear         (clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .overflow      (overflow),
    .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TILE_W-1:0] make_tile(input logic [31:0] base);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int e = 0; e < ELEMS; e++) t[e*ACC_WIDTH +: ACC_WIDTH] = base + 32'(e);
    return t;
  endfunction

  task automatic push_tile(input logic [31:0] base);
    logic [31:0] el;
    for (int e = 0; e < ELEMS; e++) begin
      el = base + 32'(e);
      sb.push_back({1'b0, el[15:0]});
      sb.push_back({(e == ELEMS - 1), el[31:16]});
    end
  endtask

  task automatic send_tile(input logic [31:0] base, input bit kept);
    results_flat = make_tile(base);
    result_valid = 1'b1;
    if (kept) push_tile(base);
    tick();
    result_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int exp_cycles);
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_valid_low"}, out_valid, 1'b0);
  endtask

  // Every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("beat_unexpected", 32'(out_data), 32'hDEAD);
      end else begin
        logic [16:0] exp;
        exp = sb.pop_front();
        check("beat_data", 32'(out_data), 32'(exp[15:0]));
        check("beat_last", 32'(out_last), 32'(exp[16]));
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    results_flat = '0;
    result_valid = 1'b0;
    clear        = 1'b0;
    out_ready    = 1'b0;
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", 32'(out_data), 0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_dropped", 32'(frames_dropped), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: single tile, consumer always ready
    out_ready    = 1'b1;
    results_flat = make_tile(32'hA000_0000);
    result_valid = 1'b1;
    push_tile(32'hA000_0000);
    check("t1_valid_pre", out_valid, 1'b0);
    tick();
    result_valid = 1'b0;
    check("t1_valid_rise", out_valid, 1'b1);
    check("t1_first_beat", 32'(out_data), 32'h0000);
    check("t1_busy", busy, 1'b1);
    wait_drain("t1", 32);

    // 2: stall on beat 0 for 10 cycles
    out_ready = 1'b0;
    send_tile(32'hC0DE_0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t2_stall_valid", out_valid, 1'b1);
      check("t2_stall_data", 32'(out_data), 32'h0000);
      check("t2_stall_last", out_last, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("t2", 32);

    // 3: two buffered tiles, third dropped, back-to-back drain
    out_ready = 1'b0;
    send_tile(32'h1000_0000, 1'b1);
    tick();
    send_tile(32'h2000_0000, 1'b1);
    tick();
    send_tile(32'h3000_0000, 1'b0);
    check("t3_overflow", overflow, 1'b1);
    check("t3_dropped", 32'(frames_dropped), 1);
    check("t3_busy", busy, 1'b1);
    out_ready = 1'b1;
    wait_drain("t3", 64);

    // 4: refill on the final beat of a full buffer
    out_ready = 1'b0;
    send_tile(32'h4000_0000, 1'b1);
    send_tile(32'h5000_0000, 1'b1);
    out_ready = 1'b1;
    repeat (31) tick();
    check("t4_last_beat", out_last, 1'b1);
    send_tile(32'h6000_0000, 1'b1);
    check("t4_no_drop", 32'(frames_dropped), 1);
    check("t4_valid", out_valid, 1'b1);
    wait_drain("t4", 64);

    // 5: clear mid-tile with a tile presented in the same cycle
    out_ready = 1'b1;
    send_tile(32'h7000_0000, 1'b1);
    repeat (7) tick();
    results_flat = make_tile(32'h8000_0000);
    result_valid = 1'b1;
    clear        = 1'b1;
    tick();
    result_valid = 1'b0;
    clear        = 1'b0;
    sb.delete();
    check("t5_valid", out_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_overflow", overflow, 1'b0);
    check("t5_dropped", 32'(frames_dropped), 0);
    tick();
    check("t5_not_captured", busy, 1'b0);
    check("t5_still_idle", out_valid, 1'b0);

    // 6: saturation of the drop counter, then reset mid-stream
    out_ready    = 1'b0;
    results_flat = make_tile(32'h9000_0000);
    result_valid = 1'b1;
    push_tile(32'h9000_0000);
    push_tile(32'h9000_0000);
    for (int i = 1; i <= 302; i++) begin
      tick();
      if (i == 256) check("t6_dropped_254", 32'(frames_dropped), 254);
      if (i == 257) check("t6_dropped_255", 32'(frames_dropped), 255);
    end
    result_valid = 1'b0;
    check("t6_dropped_sat", 32'(frames_dropped), 255);
    check("t6_overflow", overflow, 1'b1);
    out_ready = 1'b1;
    repeat (5) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_data", 32'(out_data), 0);
    check("t6_rst_last", out_last, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_overflow", overflow, 1'b0);
    check("t6_rst_dropped", 32'(frames_dropped), 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();

    // Function after reset
    send_tile(32'hE000_0000, 1'b1);
    wait_drain("t7", 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
